uart_rx_cfg: RTL
================

# uart_rx_cfg

Parametrised UART receiver that replaces the fixed 8N1 `uart_rx`. It adds configurable data width, optional parity, one or two stop bits, and 3-sample majority voting. It also reports parity and framing errors. It sits between the board RX pin and `uart_sr`, to which it delivers a byte plus a one-cycle `data_ready` strobe.

## Interface
- `CLKS_PER_TICK`, default 28: clk cycles per oversample tick; must be ≥1. The default gives about 111.6 kbaud at 50 MHz.
- `OVERSAMPLE`, default 16: ticks per bit; must be even and ≥8.
- `DATA_BITS`, default 8: payload bits, range 5..9, sent LSB first.
- `PARITY`, default `PARITY_NONE`: one of `PARITY_NONE`, `PARITY_ODD`, `PARITY_EVEN`.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: asynchronous serial line, idle high.
- `data` out `DATA_BITS`: last received payload; held until the next frame completes.
- `data_ready` out 1: one-clk pulse when a frame completes.
- `parity_err` out 1: parity mismatch on the last frame; held with `data`. Always 0 when `PARITY_NONE`.
- `frame_err` out 1: a stop bit sampled 0 on the last frame; held with `data`.
- `busy` out 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-FF synchroniser whose flops reset to 1. A third register holds the previous synchronised value for falling-edge detection.
- Tick generator:
  - Counts 0..`CLKS_PER_TICK`-1 and produces a one-cycle tick on the terminal count.
  - The counter and the in-bit tick index `s` (0..`OVERSAMPLE`-1) clear on entry to START.
- Majority voting:
  - Each bit is sampled at ticks `s` = `OVERSAMPLE`/2-1, /2 and /2+1.
  - The 2-of-3 vote is resolved at the tick with `s`=`OVERSAMPLE`/2+1.
- States:
  - IDLE: on a synchronised falling edge with `armed`=1, go to START.
  - START: vote=1 means a false start; return to IDLE with no outputs changed. Vote=0 continues to DATA.
  - DATA: shift `DATA_BITS` votes in LSB first, then go to PARITY if enabled, else STOP.
  - PARITY: compare the vote with the computed parity. ODD means the total count of 1s in data plus parity bit is odd. EVEN means that count is even.
  - STOP: resolve `STOP_BITS` votes. Any 0 sets `frame_err`.
  - Return to IDLE at the last stop-bit vote, without waiting out the rest of the bit, so the receiver resyncs on the next start edge.
- Frame completion (same clk edge):
  - `data`, `parity_err` and `frame_err` update.
  - `data_ready` is high for exactly the following cycle.
  - Completion happens even when an error flag is set.
- Break handling:
  - If the frame ends with `frame_err`, `armed` clears.
  - `armed` sets again once the synchronised `rx` reads 1.
  - Result: a line held low yields exactly one frame with `data`=0 and `frame_err`=1.
- Reset, including mid-frame:
  - State goes to IDLE; `data`, `data_ready`, `parity_err`, `frame_err` and `busy` go to 0.
  - Synchroniser flops go to 1 and `armed` goes to 1.

## Timing
- START is entered on the 3rd clk edge after `rx` falls (2 synchroniser stages plus edge detect), with ±1 cycle of input-phase uncertainty.
- Vote for bit `b` (start bit = 0) resolves `(b*OVERSAMPLE + OVERSAMPLE/2 + 2) * CLKS_PER_TICK` clk edges after START entry.
- Last stop bit index is `1 + DATA_BITS + (PARITY!=NONE) + STOP_BITS - 1`. For the default 8N1 this is `b`=9, so completion comes 4312 clk after START entry and `data_ready` is high in the cycle after that.
- `busy` rises on the START-entry edge and falls on the completion edge.
- Minimum frame spacing is zero idle bits: a start edge immediately after the stop bit is accepted.

## Structure
- Package `uart_pkg` holds:
  - the `parity_t` enum (`PARITY_NONE`/`ODD`/`EVEN`);
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_CLKS_PER_TICK`=28 and `UART_OVERSAMPLE`=16.
- Sub-module `uart_baud_tick`: parametrised tick counter with a synchronous clear input and a `tick` output. It is reused by a future `uart_tx_cfg`.

## Test plan
- Default 8N1 at 448 clk/bit: send 0xAB, then 0xCD back-to-back. Expect two `data_ready` pulses with `data`=0xAB then 0xCD, errors 0, and `uart_sr` word 0xCDAB.
- `PARITY`=EVEN: send 0x5A with parity bit 0. Expect `parity_err`=0. Repeat with the parity bit flipped. Expect `data`=0x5A and `parity_err`=1.
- False start: hold `rx` low for 84 clk (3 ticks). Expect no `data_ready`, `busy` back to 0, and `data` unchanged.
- Noise: send 0xAB with one tick (28 clk) inverted at the middle sample of data bit 3. Expect `data`=0xAB and no errors.
- Break: hold `rx` low for 20 bit times. Expect exactly one pulse with `data`=0x00 and `frame_err`=1. After `rx` returns high, send 0x3C; expect `data`=0x3C and `frame_err`=0.
- Reset: assert `rst` mid-DATA of 0x77. Expect all outputs 0 immediately. Then send 0x11; expect `data`=0x11 and a single pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and default timing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_ODD,
        PARITY_EVEN
    } parity_t;

    // ST_ prefix keeps the PARITY state clear of the top-level PARITY parameter.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int unsigned UART_CLKS_PER_TICK = 28;
    localparam int unsigned UART_OVERSAMPLE    = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLKS_PER_TICK clocks, held off while clr is high.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = UART_CLKS_PER_TICK
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1/2 stop bits, 3-sample majority vote.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = UART_CLKS_PER_TICK,
    parameter int unsigned OVERSAMPLE    = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS     = 8,
    parameter parity_t     PARITY        = PARITY_NONE,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 tick;
    logic [SW-1:0]        s;
    logic [BW-1:0]        bit_cnt;
    logic                 smp_lo;
    logic                 smp_mid;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 armed;
    logic                 fall_c;
    logic                 vote_c;
    logic                 par_mismatch_c;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_IDLE),
        .tick(tick)
    );

    assign fall_c         = rx_prev & ~rx_sync;
    assign vote_c         = (smp_lo & smp_mid) | (smp_lo & rx_sync) | (smp_mid & rx_sync);
    assign par_mismatch_c = vote_c ^ (^shreg) ^ (PARITY == PARITY_ODD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            s          <= '0;
            bit_cnt    <= '0;
            smp_lo     <= 1'b1;
            smp_mid    <= 1'b1;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            armed      <= 1'b1;
            data       <= '0;
            data_ready <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            if (rx_sync) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (fall_c && armed) begin
                        state    <= ST_START;
                        busy     <= 1'b1;
                        s        <= '0;
                        bit_cnt  <= '0;
                        par_bad  <= 1'b0;
                        stop_bad <= 1'b0;
                    end
                end
                default: begin
                    if (tick) begin
                        s <= (s == S_LAST) ? '0 : s + 1'b1;
                        if (s == S_LO) begin
                            smp_lo <= rx_sync;
                        end
                        if (s == S_MID) begin
                            smp_mid <= rx_sync;
                        end
                        // Every bit decision happens on the third sample.
                        if (s == S_HI) begin
                            case (state)
                                ST_START: begin
                                    if (vote_c) begin
                                        state <= ST_IDLE;
                                        busy  <= 1'b0;
                                    end else begin
                                        state <= ST_DATA;
                                    end
                                end
                                ST_DATA: begin
                                    shreg <= {vote_c, shreg[DATA_BITS-1:1]};
                                    if (bit_cnt == LAST_DATA) begin
                                        bit_cnt <= '0;
                                        state   <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                                    end else begin
                                        bit_cnt <= bit_cnt + 1'b1;
                                    end
                                end
                                ST_PARITY: begin
                                    par_bad <= par_mismatch_c;
                                    state   <= ST_STOP;
                                end
                                ST_STOP: begin
                                    if (bit_cnt == LAST_STOP) begin
                                        state      <= ST_IDLE;
                                        busy       <= 1'b0;
                                        data       <= shreg;
                                        data_ready <= 1'b1;
                                        parity_err <= par_bad;
                                        frame_err  <= stop_bad | ~vote_c;
                                        if (stop_bad || !vote_c) begin
                                            armed <= 1'b0;
                                        end
                                    end else begin
                                        stop_bad <= stop_bad | ~vote_c;
                                        bit_cnt  <= bit_cnt + 1'b1;
                                    end
                                end
                                default: state <= ST_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
